// File: rtl/cardinal_nic_vcq.sv
// cardinal_nic_vcq
// Network interface between one processor core and its local mesh router port.
// One DEPTH-entry input FIFO (router -> core) and two DEPTH-entry output
// queues, one per virtual channel (core -> router), so a blocked VC never
// stalls the other one.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   addr               00 in-buf(R), 01 in-status(R), 10 out-buf(W), 11 out-status(R)
//   d_in / d_out       processor write data / registered read data
//   nicEn, nicEnWr     register access enable, 1=write 0=read
//   net_si, net_ri     router offers packet on net_di / NIC can accept
//   net_di             packet from router
//   net_so, net_do     registered packet valid / data toward router
//   net_ro             router ready to accept
//   net_polarity       VC the router currently accepts
module cardinal_nic_vcq #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int VC_BIT = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicEnWr,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic cpu_rd;
    logic cpu_wr;
    assign cpu_rd = nicEn & ~nicEnWr;
    assign cpu_wr = nicEn & nicEnWr;

    // ---------------- input FIFO (router -> core) ----------------
    logic [DATA_W-1:0] in_mem [DEPTH];
    logic [PTR_W-1:0]  in_wr_ptr_reg;
    logic [PTR_W-1:0]  in_rd_ptr_reg;
    logic [CNT_W-1:0]  in_cnt_reg;
    logic [CNT_W-1:0]  in_cnt_next;
    logic              in_push;
    logic              in_pop;
    logic              in_nonempty;

    assign in_nonempty = (in_cnt_reg != '0);
    assign net_ri      = (in_cnt_reg != FULL_CNT);
    assign in_push     = net_si & net_ri;
    assign in_pop      = cpu_rd & (addr == 2'b00) & in_nonempty;
    assign in_cnt_next = in_cnt_reg + CNT_W'(in_push) - CNT_W'(in_pop);

    always_ff @(posedge clk) begin
        if (in_push)
            in_mem[in_wr_ptr_reg] <= net_di;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_wr_ptr_reg <= '0;
            in_rd_ptr_reg <= '0;
            in_cnt_reg    <= '0;
        end else begin
            if (in_push)
                in_wr_ptr_reg <= in_wr_ptr_reg + 1'b1;
            if (in_pop)
                in_rd_ptr_reg <= in_rd_ptr_reg + 1'b1;
            in_cnt_reg <= in_cnt_next;
        end
    end

    // ---------------- output queues, one per VC ----------------
    logic [1:0][CNT_W-1:0]  q_cnt;
    logic [1:0][DATA_W-1:0] q_head;
    logic [1:0]             q_full;
    logic [1:0]             q_pop;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_q
            logic [DATA_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [CNT_W-1:0]  cnt_reg;
            logic              wr_en;
            logic              rd_en;

            // Fullness comes from the registered count, so a write to a
            // full queue is dropped even if that queue pops this cycle.
            assign wr_en = cpu_wr & (addr == 2'b10) & (d_in[VC_BIT] == 1'(gi))
                         & (cnt_reg != FULL_CNT);
            // A freshly written entry is only visible through cnt_reg on the
            // next cycle, so there is no write-to-send bypass.
            assign rd_en = net_ro & (net_polarity == 1'(gi)) & (cnt_reg != '0);

            always_ff @(posedge clk) begin
                if (wr_en)
                    mem[wr_ptr_reg] <= d_in;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (wr_en)
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (rd_en)
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    cnt_reg <= cnt_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
                end
            end

            assign q_cnt[gi]  = cnt_reg;
            assign q_head[gi] = mem[rd_ptr_reg];
            assign q_full[gi] = (cnt_reg == FULL_CNT);
            assign q_pop[gi]  = rd_en;
        end
    endgenerate

    // ---------------- send to router ----------------
    logic              net_so_reg;
    logic [DATA_W-1:0] net_do_reg;
    logic              send;

    assign send = |q_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            net_so_reg <= 1'b0;
            net_do_reg <= '0;
        end else begin
            net_so_reg <= send;
            if (send)
                net_do_reg <= q_head[net_polarity];
        end
    end

    assign net_so = net_so_reg;
    assign net_do = net_do_reg;

    // ---------------- processor read port ----------------
    logic [DATA_W-1:0] in_status;
    logic [DATA_W-1:0] out_status;
    logic [DATA_W-1:0] d_out_reg;
    logic [DATA_W-1:0] d_out_next;

    always_comb begin
        in_status                = '0;
        in_status[DATA_W-1]      = in_nonempty;
        in_status[CNT_W-1:0]     = in_cnt_reg;
        out_status               = '0;
        out_status[DATA_W-1]     = q_full[1];
        out_status[DATA_W-2]     = q_full[0];
        out_status[2*CNT_W-1:CNT_W] = q_cnt[1];
        out_status[CNT_W-1:0]    = q_cnt[0];
    end

    always_comb begin
        d_out_next = '0;
        if (cpu_rd) begin
            case (addr)
                2'b00:   d_out_next = in_nonempty ? in_mem[in_rd_ptr_reg] : '0;
                2'b01:   d_out_next = in_status;
                2'b11:   d_out_next = out_status;
                default: d_out_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            d_out_reg <= '0;
        else
            d_out_reg <= d_out_next;
    end

    assign d_out = d_out_reg;

endmodule

// File: tb/tb_cardinal_nic_vcq.sv
module tb_cardinal_nic_vcq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'b00;
    logic [63:0] d_in = '0;
    logic [63:0] d_out;
    logic        nicEn = 1'b0;
    logic        nicEnWr = 1'b0;
    logic        net_si = 1'b0;
    logic        net_ri;
    logic [63:0] net_di = '0;
    logic        net_so;
    logic        net_ro = 1'b0;
    logic [63:0] net_do;
    logic        net_polarity = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    logic [63:0] exp_in[$];

    cardinal_nic_vcq #(.DATA_W(64), .DEPTH(4), .VC_BIT(63)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [63:0] d);
        addr = a; nicEn = 1'b1; nicEnWr = 1'b0;
        tick();
        d = d_out;
        nicEn = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [63:0] d);
        addr = a; d_in = d; nicEn = 1'b1; nicEnWr = 1'b1;
        tick();
        nicEn = 1'b0; nicEnWr = 1'b0;
    endtask

    task automatic net_send(input logic [63:0] d);
        net_si = 1'b1; net_di = d;
        tick();
        net_si = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] r;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL reset_net_ri got=%b exp=1", net_ri); end
        checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL reset_net_so got=%b exp=0", net_so); end
        checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL reset_d_out got=%h exp=0", d_out); end
        cpu_read(2'b01, r);
        checks++; if (r !== 64'h0) begin failures++; $display("FAIL reset_in_status got=%h exp=0", r); end
        cpu_read(2'b11, r);
        checks++; if (r !== 64'h0) begin failures++; $display("FAIL reset_out_status got=%h exp=0", r); end
        $display("test_reset done");
    endtask

    task automatic test_out_vc0();
        logic [63:0] r, e;
        int sent;
        net_ro = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = 64'h0AAA_0000_0000_0000 + 64'(i);
            exp_q0.push_back(e);
            cpu_write(2'b10, e);
            $display("write A%0d %h", i, e);
        end
        cpu_read(2'b11, r);
        checks++; if (r !== 64'h4000_0000_0000_0004) begin failures++; $display("FAIL vc0_full_status got=%h exp=%h", r, 64'h4000_0000_0000_0004); end
        cpu_write(2'b10, 64'h0AAA_0000_0000_00FF);
        cpu_read(2'b11, r);
        checks++; if (r !== 64'h4000_0000_0000_0004) begin failures++; $display("FAIL vc0_drop_status got=%h exp=%h", r, 64'h4000_0000_0000_0004); end
        net_polarity = 1'b0; net_ro = 1'b1;
        sent = 0;
        repeat (8) begin
            tick();
            if (net_so === 1'b1) begin
                sent++;
                e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 64'hDEAD;
                checks++; if (net_do !== e) begin failures++; $display("FAIL vc0_send got=%h exp=%h", net_do, e); end
                $display("send %h", net_do);
            end
        end
        net_ro = 1'b0;
        checks++; if (sent != 4) begin failures++; $display("FAIL vc0_send_count got=%0d exp=4", sent); end
        exp_q0.delete();
    endtask

    task automatic test_vc_indep();
        logic [63:0] r, e;
        int sent;
        net_ro = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = 64'h0BBB_0000_0000_0010 + 64'(i);
            exp_q0.push_back(e);
            cpu_write(2'b10, e);
        end
        e = 64'h8CCC_0000_0000_00B0;
        exp_q1.push_back(e);
        cpu_write(2'b10, e);
        net_polarity = 1'b1; net_ro = 1'b1;
        sent = 0;
        repeat (6) begin
            tick();
            if (net_so === 1'b1) begin
                sent++;
                e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 64'hDEAD;
                checks++; if (net_do !== e) begin failures++; $display("FAIL vc1_send got=%h exp=%h", net_do, e); end
                $display("send vc1 %h", net_do);
            end
        end
        net_ro = 1'b0;
        checks++; if (sent != 1) begin failures++; $display("FAIL vc1_send_count got=%0d exp=1", sent); end
        cpu_read(2'b11, r);
        checks++; if (r !== 64'h2) begin failures++; $display("FAIL vc_indep_status got=%h exp=2", r); end
        net_polarity = 1'b0; net_ro = 1'b1;
        sent = 0;
        repeat (6) begin
            tick();
            if (net_so === 1'b1) begin
                sent++;
                e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 64'hDEAD;
                checks++; if (net_do !== e) begin failures++; $display("FAIL vc0_order got=%h exp=%h", net_do, e); end
                $display("send vc0 %h", net_do);
            end
        end
        net_ro = 1'b0;
        checks++; if (sent != 2) begin failures++; $display("FAIL vc0_send_count2 got=%0d exp=2", sent); end
        exp_q0.delete(); exp_q1.delete();
    endtask

    task automatic test_in_fifo();
        logic [63:0] r, e;
        for (int i = 0; i < 4; i++) begin
            e = 64'hC0C0_0000_0000_0000 + 64'(i);
            exp_in.push_back(e);
            net_send(e);
            $display("router push C%0d %h", i, e);
        end
        checks++; if (net_ri !== 1'b0) begin failures++; $display("FAIL in_full_ri got=%b exp=0", net_ri); end
        net_send(64'hC0C0_0000_0000_0004);
        cpu_read(2'b01, r);
        checks++; if (r !== 64'h8000_0000_0000_0004) begin failures++; $display("FAIL in_status got=%h exp=%h", r, 64'h8000_0000_0000_0004); end
        for (int i = 0; i < 4; i++) begin
            cpu_read(2'b00, r);
            e = (exp_in.size() > 0) ? exp_in.pop_front() : 64'hDEAD;
            checks++; if (r !== e) begin failures++; $display("FAIL in_read got=%h exp=%h", r, e); end
            $display("cpu read %h", r);
        end
        cpu_read(2'b00, r);
        checks++; if (r !== 64'h0) begin failures++; $display("FAIL in_empty_read got=%h exp=0", r); end
        checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL in_empty_ri got=%b exp=1", net_ri); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r, e;
        for (int i = 0; i < 2; i++) begin
            e = 64'hD0D0_0000_0000_0000 + 64'(i);
            exp_in.push_back(e);
            net_send(e);
        end
        e = 64'hD0D0_0000_0000_0002;
        exp_in.push_back(e);
        net_si = 1'b1; net_di = e;
        cpu_read(2'b00, r);
        net_si = 1'b0;
        e = exp_in.pop_front();
        checks++; if (r !== e) begin failures++; $display("FAIL pushpop_data got=%h exp=%h", r, e); end
        cpu_read(2'b01, r);
        checks++; if (r !== 64'h8000_0000_0000_0002) begin failures++; $display("FAIL pushpop_count got=%h exp=%h", r, 64'h8000_0000_0000_0002); end
        for (int i = 0; i < 2; i++) begin
            cpu_read(2'b00, r);
            e = exp_in.pop_front();
            checks++; if (r !== e) begin failures++; $display("FAIL pushpop_order got=%h exp=%h", r, e); end
            $display("cpu read %h", r);
        end
    endtask

    task automatic test_illegal();
        logic [63:0] r;
        cpu_write(2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
        cpu_write(2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
        cpu_write(2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
        cpu_read(2'b11, r);
        checks++; if (r !== 64'h0) begin failures++; $display("FAIL illegal_out_status got=%h exp=0", r); end
        cpu_read(2'b01, r);
        checks++; if (r !== 64'h0) begin failures++; $display("FAIL illegal_in_status got=%h exp=0", r); end
        cpu_write(2'b10, 64'h0EEE_0000_0000_0001);
        cpu_read(2'b11, r);
        checks++; if (r !== 64'h1) begin failures++; $display("FAIL illegal_pre_status got=%h exp=1", r); end
        cpu_read(2'b10, r);
        checks++; if (r !== 64'h0) begin failures++; $display("FAIL illegal_read10 got=%h exp=0", r); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r;
        net_ro = 1'b0;
        cpu_write(2'b10, 64'h0EEE_0000_0000_0002);
        cpu_write(2'b10, 64'h0EEE_0000_0000_0003);
        net_send(64'hF0F0_0000_0000_0000);
        net_polarity = 1'b0; net_ro = 1'b1;
        tick();
        checks++; if (net_so !== 1'b1) begin failures++; $display("FAIL mid_send_so got=%b exp=1", net_so); end
        checks++; if (net_do !== 64'h0EEE_0000_0000_0001) begin failures++; $display("FAIL mid_send_do got=%h exp=%h", net_do, 64'h0EEE_0000_0000_0001); end
        reset = 1'b1;
        tick();
        checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL mid_reset_so got=%b exp=0", net_so); end
        reset = 1'b0;
        tick();
        checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL post_reset_so got=%b exp=0", net_so); end
        net_ro = 1'b0;
        cpu_read(2'b11, r);
        checks++; if (r !== 64'h0) begin failures++; $display("FAIL post_reset_out_status got=%h exp=0", r); end
        cpu_read(2'b01, r);
        checks++; if (r !== 64'h0) begin failures++; $display("FAIL post_reset_in_status got=%h exp=0", r); end
        checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL post_reset_ri got=%b exp=1", net_ri); end
    endtask

    initial begin
        test_reset();
        test_out_vc0();
        test_vc_indep();
        test_in_fifo();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
